word_extractor: RTL and testbench

Sits directly downstream of `word_clipper`. It keeps a ring buffer of the most recent audio samples, indexed by sample index. On each word boundary pair (start/end index) from the clipper, it streams exactly `OUT_LEN` samples of that word to the feature-extraction stage over a valid/ready interface. Short words are zero-padded and long words are truncated.

---
 rtl/word_pkg.sv | 15 +
 rtl/fifo.sv | 50 +++++
 rtl/sample_ring_ram.sv | 26 ++
 rtl/word_extractor.sv | 163 ++++++++++++++++
 tb/tb_word_extractor.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_pkg.sv
// Shared types for the word clipper / extractor pair: index and sample widths
// plus the extractor FSM encoding.
package word_pkg;
    localparam int IDX_W  = 32;
    localparam int DATA_W = 16;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } wx_state_t;
endpackage

// File: rtl/fifo.sv
// Generic small FIFO with registered storage and a head-of-queue output.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: no internal push guard; the producer must respect count < DEPTH.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         iclk,
    input  logic                         irstn,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    output logic                         pop_vld,
    input  logic                         pop_rdy,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign do_pop  = pop_vld && pop_rdy;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge iclk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(push_vld) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sample_ring_ram.sv
// Simple dual-port sample RAM, one write port and one synchronous read port.
// Latency: rdata valid one cycle after re; same-address read/write returns old data.
// Backpressure: none; rdata holds while re is low.
module sample_ring_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384
) (
    input  logic                       iclk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge iclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/word_extractor.sv
// Replays each accepted word from the sample ring as exactly OUT_LEN beats (zero-pad / truncate).
// Latency: ovalid two cycles after iword_valid is sampled, then one beat per cycle.
// Backpressure: oready low stalls RAM reads; a 2-entry skid buffer holds data already read.
module word_extractor #(
    parameter int DATA_W  = word_pkg::DATA_W,
    parameter int IDX_W   = word_pkg::IDX_W,
    parameter int DEPTH   = 16384,
    parameter int OUT_LEN = 8000,
    parameter int GUARD   = 1024
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic              ivalid,
    input  logic [IDX_W-1:0]  iidx,
    input  logic [DATA_W-1:0] idata,
    input  logic              iword_valid,
    input  logic [IDX_W-1:0]  istart_idx,
    input  logic [IDX_W-1:0]  iend_idx,
    output logic              ovalid,
    input  logic              oready,
    output logic [DATA_W-1:0] odata,
    output logic              olast,
    output logic              obusy,
    output logic              oword_drop,
    output logic              ooverrun
);
    import word_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(OUT_LEN + 1);
    localparam logic [IDX_W-1:0] DEPTH_I   = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] MAX_AGE   = IDX_W'(DEPTH - GUARD);
    localparam logic [IDX_W-1:0] OUT_LEN_I = IDX_W'(OUT_LEN);
    localparam logic [KW-1:0]    K_LAST    = KW'(OUT_LEN - 1);

    wx_state_t         state, state_nxt;
    logic [IDX_W-1:0]  newest;
    logic              have_data;
    logic [IDX_W-1:0]  start_q, len_q;
    logic [KW-1:0]     rd_k;
    logic [IDX_W-1:0]  span, tail, age, rd_lim, rd_done, wr_dist;
    logic              reject, accept, issue, zero_k, last_k, ovr_hit;
    logic              ovr_word, ovr_q, drop_q;
    logic              infl_vld, infl_zero, infl_last;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W:0]   head;
    logic              fifo_vld, pop;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;

    // Sign bit of a modular difference flags "negative" distances.
    assign span   = iend_idx - istart_idx;
    assign tail   = newest - iend_idx;
    assign age    = newest - istart_idx + IDX_W'(1);
    assign reject = !have_data || span[IDX_W-1] || tail[IDX_W-1] || (age > MAX_AGE);
    assign accept = (state == IDLE) && iword_valid && !reject;

    // Reads are credited against skid space plus the one read in flight.
    assign pop    = fifo_vld && oready;
    assign occ    = {1'b0, fifo_cnt} + {2'b0, infl_vld} - {2'b0, pop};
    assign issue  = (state == STREAM) && (occ < 3'd2);
    assign last_k = (rd_k == K_LAST);
    assign zero_k = (IDX_W'(rd_k) >= len_q) || ovr_word;

    // Overrun: a write lapped the word start while word data is still unread.
    assign rd_lim  = (len_q < OUT_LEN_I) ? len_q : OUT_LEN_I;
    assign rd_done = IDX_W'(rd_k) + IDX_W'(issue);
    assign wr_dist = iidx - start_q;
    assign ovr_hit = (state != IDLE) && ivalid && (wr_dist >= DEPTH_I) && (rd_done < rd_lim);

    sample_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .iclk  (iclk),
        .we    (ivalid),
        .waddr (iidx[AW-1:0]),
        .wdata (idata),
        .re    (issue),
        .raddr (AW'(start_q + IDX_W'(rd_k))),
        .rdata (ram_rdata)
    );

    fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (2)
    ) u_skid (
        .iclk     (iclk),
        .irstn    (irstn),
        .push_vld (infl_vld),
        .push_dat ({infl_last, (infl_zero ? '0 : ram_rdata)}),
        .pop_vld  (fifo_vld),
        .pop_rdy  (oready),
        .pop_dat  (head),
        .count    (fifo_cnt)
    );

    assign ovalid     = fifo_vld;
    assign odata      = fifo_vld ? head[DATA_W-1:0] : '0;
    assign olast      = fifo_vld && head[DATA_W];
    assign obusy      = (state != IDLE);
    assign oword_drop = drop_q;
    assign ooverrun   = ovr_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)          state_nxt = STREAM;
            STREAM:  if (issue && last_k) state_nxt = DRAIN;
            DRAIN:   if (pop && olast)    state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            newest    <= '0;
            have_data <= 1'b0;
        end else if (ivalid) begin
            newest    <= iidx;
            have_data <= 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            start_q   <= '0;
            len_q     <= '0;
            rd_k      <= '0;
            infl_vld  <= 1'b0;
            infl_zero <= 1'b0;
            infl_last <= 1'b0;
            ovr_word  <= 1'b0;
            ovr_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q    <= iword_valid && ((state != IDLE) || reject);
            infl_vld  <= issue;
            infl_zero <= zero_k;
            infl_last <= last_k;
            if (accept) begin
                start_q  <= istart_idx;
                len_q    <= span + IDX_W'(1);
                rd_k     <= '0;
                ovr_word <= 1'b0;
            end else if (issue) begin
                rd_k <= rd_k + KW'(1);
            end
            if (ovr_hit) begin
                ovr_word <= 1'b1;
                ovr_q    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_word_extractor.sv
// Directed bench for word_extractor with DEPTH=256, OUT_LEN=64, GUARD=16;
// samples arrive every cycle with idata equal to the low bits of the index.
module tb_word_extractor;
    logic        iclk = 1'b0;
    logic        irstn = 1'b1;
    logic        ivalid = 1'b0;
    logic [31:0] iidx = '0;
    logic [15:0] idata = '0;
    logic        iword_valid = 1'b0;
    logic [31:0] istart_idx = '0;
    logic [31:0] iend_idx = '0;
    logic        oready = 1'b0;
    logic        ovalid;
    logic [15:0] odata;
    logic        olast;
    logic        obusy;
    logic        oword_drop;
    logic        ooverrun;

    int tests = 0;
    int fails = 0;
    int idx   = 0;
    int drops = 0;
    logic [15:0] got_dat[$];
    logic        got_last[$];

    always #5 iclk = ~iclk;

    word_extractor #(
        .DATA_W (16), .IDX_W (32), .DEPTH (256), .OUT_LEN (64), .GUARD (16)
    ) dut (
        .iclk        (iclk),
        .irstn       (irstn),
        .ivalid      (ivalid),
        .iidx        (iidx),
        .idata       (idata),
        .iword_valid (iword_valid),
        .istart_idx  (istart_idx),
        .iend_idx    (iend_idx),
        .ovalid      (ovalid),
        .oready      (oready),
        .odata       (odata),
        .olast       (olast),
        .obusy       (obusy),
        .oword_drop  (oword_drop),
        .ooverrun    (ooverrun)
    );

    // One cycle: observe at the falling edge, drive the next sample/word/ready,
    // and record the beat that the coming rising edge will accept.
    task automatic cycle(input logic wv, input logic [31:0] s, input logic [31:0] e, input logic rdy);
        @(negedge iclk);
        if (oword_drop) drops++;
        ivalid      = 1'b1;
        iidx        = 32'(idx);
        idata       = 16'(idx);
        idx++;
        iword_valid = wv;
        istart_idx  = s;
        iend_idx    = e;
        oready      = rdy;
        if (ovalid && oready) begin
            got_dat.push_back(odata);
            got_last.push_back(olast);
        end
    endtask

    task automatic feed(input int upto);
        while (idx <= upto) cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic collect(input int budget, output logic done);
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle(1'b0, '0, '0, 1'b1);
            if (got_last.size() > 0 && got_last[got_last.size()-1]) done = 1'b1;
        end
    endtask

    task automatic do_reset();
        irstn       = 1'b0;
        ivalid      = 1'b0;
        iword_valid = 1'b0;
        oready      = 1'b0;
        repeat (2) @(negedge iclk);
        irstn = 1'b1;
        idx   = 0;
        drops = 0;
        got_dat.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        #1 irstn = 1'b0;
        #1;
        outs = {ovalid, olast, obusy, oword_drop, ooverrun, |odata};
        tests++;
        if (outs !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 000000", outs);
        end
        do_reset();
        // First word arrives with no sample yet registered: must be dropped.
        cycle(1'b1, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (oword_drop !== 1'b1 || obusy !== 1'b0) begin
            fails++;
            $display("FAIL no_data_drop: got drop %b busy %b, expected 1 0", oword_drop, obusy);
        end
    endtask

    task automatic test_basic();
        logic        done;
        logic [15:0] exp;
        int          first_v;
        do_reset();
        feed(199);
        cycle(1'b1, 32'd100, 32'd139, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (obusy !== 1'b1 || ovalid !== 1'b0) begin
            fails++;
            $display("FAIL s1_busy_edge: got busy %b valid %b, expected 1 0", obusy, ovalid);
        end
        first_v = 0;
        for (int k = 2; k <= 6 && first_v == 0; k++) begin
            cycle(1'b0, '0, '0, 1'b1);
            if (ovalid) first_v = k;
        end
        tests++;
        if (first_v != 3) begin
            fails++;
            $display("FAIL s1_valid_latency: got %0d cycles, expected 3", first_v);
        end
        collect(200, done);
        tests++;
        if (done !== 1'b1 || got_dat.size() != 64) begin
            fails++;
            $display("FAIL s1_beat_count: got %0d beats, expected 64", got_dat.size());
        end
        for (int k = 0; k < got_dat.size() && k < 64; k++) begin
            exp = (k < 40) ? 16'(100 + k) : 16'd0;
            tests++;
            if (got_dat[k] !== exp || got_last[k] !== (k == 63)) begin
                fails++;
                $display("FAIL s1_beat%0d: got data %0d last %b, expected %0d %b", k, got_dat[k], got_last[k], exp, (k == 63));
            end
        end
        cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (obusy !== 1'b0 || ovalid !== 1'b0) begin
            fails++;
            $display("FAIL s1_busy_release: got busy %b valid %b, expected 0 0", obusy, ovalid);
        end
    endtask

    task automatic test_truncate();
        logic        done;
        logic [15:0] exp;
        do_reset();
        feed(180);
        cycle(1'b1, 32'd50, 32'd149, 1'b1);
        collect(200, done);
        tests++;
        if (done !== 1'b1 || got_dat.size() != 64 || drops != 0) begin
            fails++;
            $display("FAIL s2_count: got %0d beats %0d drops, expected 64 0", got_dat.size(), drops);
        end
        for (int k = 0; k < got_dat.size() && k < 64; k++) begin
            exp = 16'(50 + k);
            tests++;
            if (got_dat[k] !== exp || got_last[k] !== (k == 63)) begin
                fails++;
                $display("FAIL s2_beat%0d: got data %0d last %b, expected %0d %b", k, got_dat[k], got_last[k], exp, (k == 63));
            end
        end
    endtask

    task automatic test_too_old();
        logic saw_v, saw_b;
        do_reset();
        feed(250);
        cycle(1'b1, 32'd10, 32'd20, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (oword_drop !== 1'b1) begin
            fails++;
            $display("FAIL s3_drop_pulse: got %b, expected 1", oword_drop);
        end
        saw_v = 1'b0;
        saw_b = 1'b0;
        // End index beyond the newest sample must also be rejected.
        cycle(1'b1, 32'd240, 32'd400, 1'b1);
        repeat (8) begin
            cycle(1'b0, '0, '0, 1'b1);
            saw_v |= ovalid;
            saw_b |= obusy;
        end
        tests++;
        if (saw_v !== 1'b0 || saw_b !== 1'b0 || drops != 2) begin
            fails++;
            $display("FAIL s3_rejects: got valid %b busy %b drops %0d, expected 0 0 2", saw_v, saw_b, drops);
        end
    endtask

    task automatic test_back_to_back();
        logic        stall, sl, done;
        logic [15:0] sd, exp;
        do_reset();
        feed(199);
        cycle(1'b1, 32'd100, 32'd139, 1'b0);
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle((i == 20), 32'd150, 32'd160, (i % 2 == 0));
            if (stall) begin
                tests++;
                if (ovalid !== 1'b1 || odata !== sd || olast !== sl) begin
                    fails++;
                    $display("FAIL s4_hold: got valid %b data %0d last %b, expected 1 %0d %b", ovalid, odata, olast, sd, sl);
                end
            end
            stall = ovalid && !oready;
            sd    = odata;
            sl    = olast;
            if (got_last.size() > 0 && got_last[got_last.size()-1]) done = 1'b1;
        end
        repeat (2) cycle(1'b0, '0, '0, 1'b1);
        tests++;
        if (got_dat.size() != 64 || drops != 1) begin
            fails++;
            $display("FAIL s4_count: got %0d beats %0d drops, expected 64 1", got_dat.size(), drops);
        end
        for (int k = 0; k < got_dat.size() && k < 64; k++) begin
            exp = (k < 40) ? 16'(100 + k) : 16'd0;
            tests++;
            if (got_dat[k] !== exp || got_last[k] !== (k == 63)) begin
                fails++;
                $display("FAIL s4_beat%0d: got data %0d last %b, expected %0d %b", k, got_dat[k], got_last[k], exp, (k == 63));
            end
        end
    endtask

    task automatic test_overrun();
        logic        done;
        logic [15:0] exp;
        do_reset();
        feed(200);
        cycle(1'b1, 32'd0, 32'd63, 1'b0);
        while (idx <= 256) cycle(1'b0, '0, '0, 1'b0);
        tests++;
        if (ooverrun !== 1'b0) begin
            fails++;
            $display("FAIL s5_pre_overrun: got %b, expected 0", ooverrun);
        end
        collect(200, done);
        tests++;
        if (ooverrun !== 1'b1 || got_dat.size() != 64) begin
            fails++;
            $display("FAIL s5_overrun: got flag %b beats %0d, expected 1 64", ooverrun, got_dat.size());
        end
        // Beats 0 and 1 were already in the skid buffer when slot 0 was overwritten.
        for (int k = 0; k < got_dat.size() && k < 64; k++) begin
            exp = (k == 1) ? 16'd1 : 16'd0;
            tests++;
            if (got_dat[k] !== exp || got_last[k] !== (k == 63)) begin
                fails++;
                $display("FAIL s5_beat%0d: got data %0d last %b, expected %0d %b", k, got_dat[k], got_last[k], exp, (k == 63));
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [5:0]  outs;
        logic        done;
        logic [15:0] exp;
        int          n;
        do_reset();
        feed(199);
        cycle(1'b1, 32'd100, 32'd139, 1'b1);
        n = 0;
        while (got_dat.size() < 20 && n < 100) begin
            cycle(1'b0, '0, '0, 1'b1);
            n++;
        end
        @(posedge iclk);
        #2;
        tests++;
        if (ovalid !== 1'b1 || obusy !== 1'b1) begin
            fails++;
            $display("FAIL s6_mid_word: got valid %b busy %b, expected 1 1", ovalid, obusy);
        end
        irstn = 1'b0;
        #1;
        outs = {ovalid, olast, obusy, oword_drop, ooverrun, |odata};
        tests++;
        if (outs !== 6'b0) begin
            fails++;
            $display("FAIL s6_async_reset: got %b, expected 000000", outs);
        end
        do_reset();
        feed(199);
        cycle(1'b1, 32'd100, 32'd139, 1'b1);
        collect(200, done);
        tests++;
        if (done !== 1'b1 || got_dat.size() != 64) begin
            fails++;
            $display("FAIL s6_count: got %0d beats, expected 64", got_dat.size());
        end
        for (int k = 0; k < got_dat.size() && k < 64; k++) begin
            exp = (k < 40) ? 16'(100 + k) : 16'd0;
            tests++;
            if (got_dat[k] !== exp || got_last[k] !== (k == 63)) begin
                fails++;
                $display("FAIL s6_beat%0d: got data %0d last %b, expected %0d %b", k, got_dat[k], got_last[k], exp, (k == 63));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_too_old();
        test_back_to_back();
        test_overrun();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
